// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_pkg
//  Description : Shared definitions for the UART receive path. Holds the
//                receiver state encoding, the 8N1 frame constants, the
//                memory-mapped device addresses decoded by dmem, and the
//                baud-divisor helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

  // Receiver state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // 8N1 frame shape
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;   // start-bit centre, in oversample ticks

  // Device addresses seen by dmem
  localparam logic [31:0] RX_DATA_ADDR = 32'ha00003fc;
  localparam logic [31:0] RX_STAT_ADDR = 32'ha00003fd;

  // Oversample divisor: CLK_HZ/(BAUD*16), rounded down, never below 1.
  function automatic int uart_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fifo
//  Description : Byte FIFO with first-word fall-through output. Count is kept
//                separately from the pointers so full and empty never alias.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push, din       - write strobe and data
//                pop             - read strobe (ignored when empty)
//                dout            - head byte, 0 when empty
//                empty, full     - occupancy flags
//                count           - bytes held (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem_q[rptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (w_do_push) wptr_d = wptr_q + AW'(1);
    if (w_do_pop)  rptr_d = rptr_q + AW'(1);
    count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 8N1 UART receiver with 16x oversampling feeding a byte FIFO.
//                Sticky overflow and framing-error flags.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                rxd             - asynchronous serial input, idle high
//                rd_en           - pop pulse from the dmem read path
//                clr_err         - clears the sticky error flags
//                dout            - FIFO head byte, 0 when empty
//                empty, count    - FIFO occupancy
//                overflow        - byte arrived while FIFO was full
//                frame_err       - stop bit sampled low
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rxd,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [7:0]              dout,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    frame_err
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          sync1_q, sync2_q;
  logic          rxd_s;
  logic [TW-1:0] tick_q, tick_d;
  logic          w_tick;
  logic [3:0]    samp_q, samp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    state_q, state_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic          w_push;
  logic          w_ferr_set;
  logic          w_ovf_set;
  logic          w_full;

  assign rxd_s  = sync2_q;
  assign w_tick = (tick_q == TW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    tick_d     = w_tick ? '0 : tick_q + TW'(1);
    samp_d     = w_tick ? samp_q + 4'd1 : samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Align the oversample phase to the falling edge of the start bit.
        if (!rxd_s) begin
          state_d = ST_START;
          tick_d  = '0;
          samp_d  = '0;
        end
      end
      ST_START: begin
        if (w_tick && samp_q == 4'(MID_SAMPLE)) begin
          if (!rxd_s) begin
            state_d = ST_DATA;
            samp_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        // samp_q==15 lands one bit period after the start-bit centre.
        if (w_tick && samp_q == 4'(OVERSAMPLE - 1)) begin
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick && samp_q == 4'(OVERSAMPLE - 1)) begin
          if (rxd_s) begin
            w_push  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            state_d    = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full FIFO only accepts when the same cycle also pops.
  assign w_ovf_set = w_push && w_full && !rd_en;

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    ovf_d  = w_ovf_set  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    ferr_d = w_ferr_set ? 1'b1 : (clr_err ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tick_q  <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      tick_q  <= tick_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (rd_en),
    .din   (shift_q),
    .dout  (dout),
    .empty (empty),
    .full  (w_full),
    .count (count)
  );

  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo at 16 clocks per bit.
//                A queue model of the FIFO and flags is checked against the
//                DUT every cycle; directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] dout;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ (1600000),
    .BAUD   (100000),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .dout      (dout),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  // Model state
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_ferr;
  bit         sched_push;
  bit         sched_ferr;
  logic [7:0] sched_byte;
  bit         cmp_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // One clock. Inputs set by the caller are sampled at this edge; the model
  // applies the same edge's effects and the task returns 1 ns later.
  task automatic step();
    int  n;
    bit  do_pop;
    bit  set_ovf;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      n       = mq.size();
      do_pop  = rd_en && (n > 0);
      set_ovf = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (sched_push) begin
        if (n < DEPTH || do_pop) mq.push_back(sched_byte);
        else set_ovf = 1'b1;
      end
      m_ovf  = set_ovf    ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_ferr = sched_ferr ? 1'b1 : (clr_err ? 1'b0 : m_ferr);
    end
    sched_push = 1'b0;
    sched_ferr = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  // Drive one 160-clock frame. The line low before edge 1 reaches the
  // receiver after two synchronizer edges, is seen at edge 3, the start-bit
  // centre is checked 8 ticks later (edge 11), each data bit 16 ticks after
  // that, and the stop bit at edge 11+8*16+16 = 155: the push lands there.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pop_at, input bit clr_at);
    int bi;
    for (int i = 0; i < 160; i++) begin
      bi  = i / 16;
      rxd = (bi == 0) ? 1'b0 : ((bi == 9) ? stop : b[bi-1]);
      if (i == 154) begin
        sched_push = stop;
        sched_ferr = !stop;
        sched_byte = b;
        rd_en      = pop_at;
        clr_err    = clr_at;
      end
      step();
      rd_en   = 1'b0;
      clr_err = 1'b0;
    end
    rxd = 1'b1;
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_dout",      {24'd0, dout},      {24'd0, (mq.size() != 0) ? mq[0] : 8'h00});
      chk("cyc_empty",     {31'd0, empty},     {31'd0, (mq.size() == 0)});
      chk("cyc_count",     {27'd0, count},     mq.size());
      chk("cyc_overflow",  {31'd0, overflow},  {31'd0, m_ovf});
      chk("cyc_frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    end
  end

  initial begin
    rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    sched_push = 1'b0; sched_ferr = 1'b0; sched_byte = 8'h00;
    m_ovf = 1'b0; m_ferr = 1'b0;
    step(); step();
    cmp_en = 1'b1;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_dout",  {24'd0, dout},  32'h00);
    chk("rst_ovf",   {31'd0, overflow},  32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Single frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("single_dout",  {24'd0, dout},  32'hA5);
    chk("single_count", {27'd0, count}, 32'd1);
    idle(3);
    pop();
    chk("single_pop_empty", {31'd0, empty}, 32'd1);
    chk("single_pop_dout",  {24'd0, dout},  32'h00);

    // Glitch rejection, then a frame whose push coincides with a pop on empty
    rxd = 1'b0;
    for (int i = 0; i < 4; i++) step();
    idle(30);
    chk("glitch_count", {27'd0, count},     32'd0);
    chk("glitch_ferr",  {31'd0, frame_err}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("empty_pushpop_count", {27'd0, count}, 32'd1);
    chk("empty_pushpop_dout",  {24'd0, dout},  32'h5A);
    pop();

    // Framing error, clear, recovery
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("frame_count", {27'd0, count},     32'd0);
    chk("frame_ferr",  {31'd0, frame_err}, 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("frame_clr", {31'd0, frame_err}, 32'd0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk("frame_recover_dout", {24'd0, dout}, 32'h11);
    pop();
    // Set wins over a same-cycle clear
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("set_beats_clr", {31'd0, frame_err}, 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;

    // Overflow and pointer wrap
    for (int k = 0; k < 17; k++) send_frame(8'(k), 1'b1, 1'b0, 1'b0);
    chk("ovf_count", {27'd0, count},    32'd16);
    chk("ovf_flag",  {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("ovf_read", {24'd0, dout}, k);
      pop();
    end
    chk("ovf_drained", {31'd0, empty}, 32'd1);
    send_frame(8'h20, 1'b1, 1'b0, 1'b0);
    send_frame(8'h21, 1'b1, 1'b0, 1'b0);
    chk("wrap_read0", {24'd0, dout}, 32'h20);
    pop();
    chk("wrap_read1", {24'd0, dout}, 32'h21);
    pop();
    clr_err = 1'b1; step(); clr_err = 1'b0;

    // Full with concurrent pop
    for (int k = 0; k < 16; k++) send_frame(8'h40 + 8'(k), 1'b1, 1'b0, 1'b0);
    send_frame(8'h99, 1'b1, 1'b1, 1'b0);
    chk("fullpop_count", {27'd0, count},    32'd16);
    chk("fullpop_ovf",   {31'd0, overflow}, 32'd0);
    for (int k = 1; k < 16; k++) begin
      chk("fullpop_read", {24'd0, dout}, 32'h40 + k);
      pop();
    end
    chk("fullpop_last", {24'd0, dout}, 32'h99);
    pop();

    // Reset during data bit 4 with three bytes queued
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", {27'd0, count}, 32'd3);
    rxd = 1'b0;
    for (int i = 0; i < 16; i++) step();
    for (int bi = 0; bi < 4; bi++) begin
      rxd = bi[0];
      for (int i = 0; i < 16; i++) step();
    end
    rxd = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1; rxd = 1'b1;
    step(); step();
    chk("midrst_count", {27'd0, count}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    rst = 1'b0;
    idle(5);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    chk("after_rst_dout", {24'd0, dout}, 32'h7E);
    pop();

    // Line already low when reset releases counts as a start bit
    rst = 1'b1; rxd = 1'b0;
    step();
    rst = 1'b0;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    chk("low_at_rst_dout",  {24'd0, dout},  32'hC3);
    chk("low_at_rst_count", {27'd0, count}, 32'd1);
    idle(4);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial line rate; the 16x oversample divisor is DIV = CLK_HZ/(BAUD*16), rounded down and at least 1.
REQ-003 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 2 to 256.
REQ-004 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 rxd  input  1  asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-007 rd_en  input  1  pop request from the dmem read path; a one-cycle pulse.
REQ-008 clr_err  input  1  clears the sticky error flags.
REQ-009 dout  output  8  head byte of the FIFO (first-word fall-through); 0 when empty.
REQ-010 empty  output  1  FIFO holds no bytes.
REQ-011 count  output  $clog2(DEPTH)+1  number of bytes held.
REQ-012 overflow  output  1  sticky; a byte was received while the FIFO was full.
REQ-013 frame_err  output  1  sticky; a stop bit was sampled low.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer; the receiver uses only the synchronized value (rxd_s).
REQ-015 A tick counter SHALL assert a one-cycle tick every DIV clocks; a sample counter (0..15) SHALL advance on each tick.
REQ-016 The receiver SHALL use the states IDLE, START, DATA, STOP and BREAK.
REQ-017 In IDLE, when rxd_s is low, the receiver SHALL clear both counters and go to START.
REQ-018 In START, at sample count 7, the receiver SHALL go to DATA if rxd_s is low; otherwise it SHALL return to IDLE (glitch rejection, nothing pushed).
REQ-019 In DATA, the receiver SHALL sample rxd_s every 16 ticks (mid-bit) into the shift register, LSB first; after the 8th bit it SHALL go to STOP.
REQ-020 In STOP, at the mid-bit sample, if rxd_s is high the byte SHALL be pushed and the receiver SHALL go to IDLE.
REQ-021 In STOP, if the mid-bit sample is low, the byte SHALL be discarded, frame_err set, and the receiver SHALL go to BREAK.
REQ-022 In BREAK, the receiver SHALL wait for rxd_s high, then go to IDLE.
REQ-023 A push SHALL be visible on dout, empty and count on the cycle after the stop sample.
REQ-024 rd_en with empty=0 SHALL pop the head; the next byte SHALL appear on dout in the following cycle.
REQ-025 rd_en with empty=1 SHALL be ignored, with no pointer or count change.
REQ-026 A push when full with no pop SHALL drop the byte and set overflow; FIFO contents SHALL be unchanged.
REQ-027 A simultaneous push and pop when full SHALL perform both; count stays DEPTH and overflow is not set.
REQ-028 A simultaneous push and pop when empty SHALL ignore the pop and perform the push.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be held separately, so full and empty are unambiguous.
REQ-030 clr_err SHALL clear both sticky flags; if a set event occurs in the same cycle, the set SHALL win.

Reset
REQ-031 While rst is high: state = IDLE, all counters = 0, pointers = 0, count = 0, empty = 1, dout = 0, overflow = 0, frame_err = 0, synchronizer flops = 1.
REQ-032 rst asserted mid-frame SHALL abandon the frame and flush the FIFO.
REQ-033 After rst deasserts, a line already low SHALL be treated as a new start bit.

Structure
REQ-034 A shared package SHALL hold the receiver state encoding, the 8N1 frame constants, and the device address RX_DATA_ADDR = 32'ha00003fc and RX_STAT_ADDR = 32'ha00003fd, used by dmem when decoding.
REQ-035 The FIFO SHALL be a sub-module named rx_fifo (parameter DEPTH; push, pop, din, dout, empty, full, count); the receiver FSM stays in uart_rx_fifo.

Verification (CLK_HZ=1600000, BAUD=100000, so DIV=1 and 16 clocks per bit)
REQ-036 Single frame: send 0xA5 -> empty falls 1 cycle after the stop mid-sample; dout=0xA5; count=1; one rd_en -> empty=1, dout=0.
REQ-037 Glitch: rxd low for 4 clocks, then high -> no push; state returns to IDLE; frame_err=0.
REQ-038 Framing: send 0x3C with the stop bit low, then idle -> count=0, frame_err=1; then clr_err -> frame_err=0; then send 0x11 -> dout=0x11.
REQ-039 Overflow and wrap: send 17 bytes 0x00..0x10 with no reads -> count=16, overflow=1; reads return 0x00..0x0F in order; then send 0x20 and 0x21 -> pointers wrap and reads return 0x20, 0x21.
REQ-040 Full with concurrent pop: FIFO full, rd_en on the push cycle -> count stays 16, overflow=0, and the last pop returns the new byte.
REQ-041 Reset mid-frame: assert rst during data bit 4 with 3 bytes queued -> count=0, empty=1; a clean next frame 0x7E is received correctly.
